// File: rtl/pkt_cap_pkg.sv
// Shared types and constants for the packet capture controller.
package pkt_cap_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } cap_state_t;

   localparam logic [15:0] LED_IDLE  = 16'h5555;
   localparam logic [15:0] LED_ARMED = 16'hAAAA;
   localparam logic [15:0] LED_CAPT  = 16'hFFFF;

endpackage

// File: rtl/ram_v1.sv
// Single-port word RAM, synchronous write, one-cycle registered read (old data on collision).
module ram_v1 #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];

   // Storage write and registered read port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[addr] <= data_in;
      end
      data_out <= mem_r[addr];
   end

endmodule

// File: rtl/pkt_capture_ctrl.sv
// Captures one Avalon-ST packet per arm request into ram_v1 and steps the
// captured words out on the LEDs.
module pkt_capture_ctrl
   import pkt_cap_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int EMPTY_WIDTH = $clog2(WIDTH / 8)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   arm,
   input  logic                   step,
   output logic                   ready,
   input  logic [WIDTH-1:0]       data,
   input  logic                   valid,
   input  logic                   sop,
   input  logic                   eop,
   input  logic [EMPTY_WIDTH-1:0] empty,
   output logic [15:0]            LEDS,
   output logic [ADDR_WIDTH:0]    pkt_len,
   output logic [EMPTY_WIDTH-1:0] last_empty,
   output logic                   overflow,
   output logic                   sop_err,
   output logic                   busy
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH:0]   LEN_ZERO  = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0]   LEN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   LEN_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};

   cap_state_t             state_r;
   logic [ADDR_WIDTH-1:0]  wr_ptr_r;
   logic [ADDR_WIDTH-1:0]  rd_ptr_r;
   logic [ADDR_WIDTH-1:0]  ram_addr_s;
   logic [ADDR_WIDTH:0]    rd_inc_s;
   logic [WIDTH-1:0]       ram_q_s;
   logic                   beat_s;
   logic                   restart_s;
   logic                   wr_en_s;
   logic                   unused_s;

   assign ready    = 1'b1;
   assign beat_s   = valid & ready;
   assign rd_inc_s = {1'b0, rd_ptr_r} + LEN_ONE;
   assign unused_s = &{1'b0, ram_q_s[WIDTH-1:16]};

   // RAM port steering: writes follow the beat, readout follows rd_ptr.
   always_comb begin
      restart_s  = 1'b0;
      wr_en_s    = 1'b0;
      ram_addr_s = rd_ptr_r;
      case (state_r)
         ARMED: begin
            ram_addr_s = wr_ptr_r;
            wr_en_s    = beat_s & sop;
         end
         CAPTURE: begin
            // A mid-packet sop restarts the capture, so that beat goes to word 0.
            restart_s  = beat_s & sop & ~eop;
            ram_addr_s = restart_s ? ADDR_ZERO : wr_ptr_r;
            wr_en_s    = beat_s;
         end
         default: begin
            ram_addr_s = rd_ptr_r;
            wr_en_s    = 1'b0;
         end
      endcase
   end

   ram_v1 #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (WIDTH)
   ) u_ram (
      .clk      (clk),
      .wr_en    (wr_en_s),
      .addr     (ram_addr_s),
      .data_in  (data),
      .data_out (ram_q_s)
   );

   // Capture FSM, pointers and packet bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         wr_ptr_r   <= ADDR_ZERO;
         rd_ptr_r   <= ADDR_ZERO;
         pkt_len    <= LEN_ZERO;
         last_empty <= {EMPTY_WIDTH{1'b0}};
         overflow   <= 1'b0;
         sop_err    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (arm) begin
                  state_r  <= ARMED;
                  wr_ptr_r <= ADDR_ZERO;
                  overflow <= 1'b0;
                  sop_err  <= 1'b0;
               end
            end
            ARMED: begin
               if (beat_s && sop) begin
                  wr_ptr_r <= ADDR_ONE;
                  if (eop) begin
                     state_r    <= DONE;
                     pkt_len    <= LEN_ONE;
                     last_empty <= empty;
                     rd_ptr_r   <= ADDR_ZERO;
                  end else begin
                     state_r <= CAPTURE;
                  end
               end
            end
            CAPTURE: begin
               if (beat_s) begin
                  if (eop) begin
                     state_r    <= DONE;
                     pkt_len    <= {1'b0, wr_ptr_r} + LEN_ONE;
                     last_empty <= empty;
                     rd_ptr_r   <= ADDR_ZERO;
                     wr_ptr_r   <= wr_ptr_r + ADDR_ONE;
                  end else if (restart_s) begin
                     wr_ptr_r <= ADDR_ONE;
                     sop_err  <= 1'b1;
                  end else if (wr_ptr_r == ADDR_MAX) begin
                     state_r  <= DONE;
                     overflow <= 1'b1;
                     pkt_len  <= LEN_FULL;
                     rd_ptr_r <= ADDR_ZERO;
                  end else begin
                     wr_ptr_r <= wr_ptr_r + ADDR_ONE;
                  end
               end
            end
            DONE: begin
               if (arm) begin
                  state_r  <= ARMED;
                  wr_ptr_r <= ADDR_ZERO;
                  overflow <= 1'b0;
                  sop_err  <= 1'b0;
               end else if (step) begin
                  rd_ptr_r <= (rd_inc_s >= pkt_len) ? ADDR_ZERO : rd_ptr_r + ADDR_ONE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Status outputs and LED display select.
   always_comb begin
      busy = 1'b0;
      LEDS = LED_IDLE;
      case (state_r)
         IDLE: begin
            LEDS = LED_IDLE;
         end
         ARMED: begin
            LEDS = LED_ARMED;
            busy = 1'b1;
         end
         CAPTURE: begin
            LEDS = LED_CAPT;
            busy = 1'b1;
         end
         DONE: begin
            LEDS = ram_q_s[15:0];
         end
         default: begin
            LEDS = LED_IDLE;
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_pkt_capture_ctrl.sv
// Bench for pkt_capture_ctrl: directed vector table plus random traffic
// compared against a queue-based packet model.
module tb_pkt_capture_ctrl;

   localparam int W     = 32;
   localparam int AW    = 3;
   localparam int EW    = 2;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst, arm, step, valid, sop, eop;
   logic [EW-1:0] empty;
   logic [W-1:0]  data;
   logic          ready, overflow, sop_err, busy;
   logic [15:0]   leds;
   logic [AW:0]   pkt_len;
   logic [EW-1:0] last_empty;

   always #5 clk = ~clk;

   pkt_capture_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .EMPTY_WIDTH(EW)) dut (
      .clk(clk), .rst(rst), .arm(arm), .step(step), .ready(ready),
      .data(data), .valid(valid), .sop(sop), .eop(eop), .empty(empty),
      .LEDS(leds), .pkt_len(pkt_len), .last_empty(last_empty),
      .overflow(overflow), .sop_err(sop_err), .busy(busy)
   );

   typedef enum {M_IDLE, M_ARMED, M_CAPT, M_DONE} mmode_t;
   mmode_t      m_mode;
   logic [31:0] cap[$];
   int          m_len, m_le, m_rd;
   bit          m_ovf, m_serr;
   bit          led_known;
   logic [15:0] led_exp;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        a, s, v, so, eo;
      logic [1:0]  em;
      logic [31:0] d;
      logic [15:0] e_leds;
      bit          ck;
      int          e_len, e_le;
      bit          e_ovf, e_serr, e_busy;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode = M_IDLE; cap = {}; m_len = 0; m_le = 0; m_rd = 0;
      m_ovf = 1'b0; m_serr = 1'b0;
      led_known = 1'b1; led_exp = 16'h5555;
   endfunction

   function automatic void model_step(input logic a, s, v, so, eo, input logic [1:0] em,
                                      input logic [31:0] d);
      mmode_t old_mode = m_mode;
      int     old_rd   = m_rd;
      case (m_mode)
         M_IDLE: if (a) begin m_mode = M_ARMED; m_ovf = 0; m_serr = 0; end
         M_ARMED: if (v && so) begin
            cap = {d};
            if (eo) begin m_mode = M_DONE; m_len = 1; m_le = em; m_rd = 0; end
            else m_mode = M_CAPT;
         end
         M_CAPT: if (v) begin
            if (eo) begin
               cap.push_back(d); m_mode = M_DONE; m_len = cap.size(); m_le = em; m_rd = 0;
            end else if (so) begin
               cap = {d}; m_serr = 1;
            end else begin
               cap.push_back(d);
               if (cap.size() == DEPTH) begin m_mode = M_DONE; m_ovf = 1; m_len = DEPTH; m_rd = 0; end
            end
         end
         M_DONE: if (a) begin m_mode = M_ARMED; m_ovf = 0; m_serr = 0; end
                 else if (s) m_rd = (m_rd + 1) % m_len;
         default: ;
      endcase
      led_known = 1'b1;
      case (m_mode)
         M_IDLE:  led_exp = 16'h5555;
         M_ARMED: led_exp = 16'hAAAA;
         M_CAPT:  led_exp = 16'hFFFF;
         default: begin
            // Readout lags rd by one cycle, so the first DONE cycle is unknown.
            if (old_mode == M_DONE) begin
               logic [31:0] w;
               w = cap[old_rd];
               led_exp = w[15:0];
            end else led_known = 1'b0;
         end
      endcase
   endfunction

   task automatic tick(input logic a, s, v, so, eo, input logic [1:0] em,
                       input logic [31:0] d, input logic r);
      @(negedge clk);
      rst = r; arm = a; step = s; valid = v; sop = so; eop = eo; empty = em; data = d;
      if (r) model_reset();
      else model_step(a, s, v, so, eo, em, d);
      @(posedge clk);
      #1;
      chk("pkt_len", 32'(pkt_len), m_len);
      chk("last_empty", 32'(last_empty), m_le);
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("sop_err", 32'(sop_err), 32'(m_serr));
      chk("busy", 32'(busy), 32'((m_mode == M_ARMED) || (m_mode == M_CAPT)));
      chk("ready", 32'(ready), 32'd1);
      if (led_known) chk("leds", 32'(leds), 32'(led_exp));
   endtask

   function automatic vec_t mk(input logic a, s, v, so, eo, input logic [1:0] em,
                               input logic [31:0] d, input logic [15:0] el, input bit ck,
                               input int len, le, input bit ovf, serr, bsy);
      vec_t t;
      t.a = a; t.s = s; t.v = v; t.so = so; t.eo = eo; t.em = em; t.d = d;
      t.e_leds = el; t.ck = ck; t.e_len = len; t.e_le = le;
      t.e_ovf = ovf; t.e_serr = serr; t.e_busy = bsy;
      return t;
   endfunction

   initial begin
      logic [15:0] words[5];
      rst = 1'b1; arm = 1'b0; step = 1'b0; valid = 1'b0; sop = 1'b0; eop = 1'b0;
      empty = 2'd0; data = 32'd0;

      // Pre-arm traffic, stray beat in ARMED, 4-beat packet, readout with wrap.
      tbl.push_back(mk(0,0,1,1,0,0,32'hdead,    16'h5555,1, 0,0,0,0,0));
      tbl.push_back(mk(1,0,1,1,0,0,32'hbeef,    16'hAAAA,1, 0,0,0,0,1));
      tbl.push_back(mk(0,0,1,0,0,0,32'h99,      16'hAAAA,1, 0,0,0,0,1));
      tbl.push_back(mk(0,0,1,1,0,0,32'h11,      16'hFFFF,1, 0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,32'h77,      16'hFFFF,1, 0,0,0,0,1));
      tbl.push_back(mk(0,0,1,0,0,0,32'h22,      16'hFFFF,1, 0,0,0,0,1));
      tbl.push_back(mk(0,0,1,0,0,0,32'h33,      16'hFFFF,1, 0,0,0,0,1));
      tbl.push_back(mk(0,0,1,0,1,2,32'h44,      16'h0000,0, 4,2,0,0,0));
      words = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0011};
      for (int k = 0; k < 5; k++) begin
         tbl.push_back(mk(0,0,0,0,0,0,32'h0, words[k],1, 4,2,0,0,0));
         if (k < 4) tbl.push_back(mk(0,1,0,0,0,0,32'h0, words[k],1, 4,2,0,0,0));
      end
      // Single-beat packet.
      tbl.push_back(mk(1,0,0,0,0,0,32'h0,       16'hAAAA,1, 4,2,0,0,1));
      tbl.push_back(mk(0,0,1,1,1,1,32'h12345678,16'h0000,0, 1,1,0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0,32'h0,       16'h5678,1, 1,1,0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0,32'h0,       16'h5678,1, 1,1,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,       16'h5678,1, 1,1,0,0,0));
      // 12-beat packet into an 8-word RAM.
      tbl.push_back(mk(1,0,0,0,0,0,32'h0,       16'hAAAA,1, 1,1,0,0,1));
      tbl.push_back(mk(0,0,1,1,0,0,32'h100,     16'hFFFF,1, 1,1,0,0,1));
      for (int k = 1; k < 7; k++)
         tbl.push_back(mk(0,0,1,0,0,0,32'h100 + 32'(k), 16'hFFFF,1, 1,1,0,0,1));
      tbl.push_back(mk(0,0,1,0,0,0,32'h107,     16'h0000,0, 8,1,1,0,0));
      for (int k = 8; k < 11; k++)
         tbl.push_back(mk(0,0,1,0,0,0,32'h100 + 32'(k), 16'h0100,1, 8,1,1,0,0));
      tbl.push_back(mk(0,0,1,0,1,0,32'h10b,     16'h0100,1, 8,1,1,0,0));
      tbl.push_back(mk(0,1,0,0,0,0,32'h0,       16'h0100,1, 8,1,1,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,       16'h0101,1, 8,1,1,0,0));
      // Mid-packet sop restart.
      tbl.push_back(mk(1,0,0,0,0,0,32'h0,       16'hAAAA,1, 8,1,0,0,1));
      tbl.push_back(mk(0,0,1,1,0,0,32'hA0,      16'hFFFF,1, 8,1,0,0,1));
      tbl.push_back(mk(0,0,1,0,0,0,32'hA1,      16'hFFFF,1, 8,1,0,0,1));
      tbl.push_back(mk(0,0,1,1,0,0,32'hB0,      16'hFFFF,1, 8,1,0,1,1));
      tbl.push_back(mk(0,0,1,0,0,0,32'hB1,      16'hFFFF,1, 8,1,0,1,1));
      tbl.push_back(mk(0,0,1,0,1,3,32'hB2,      16'h0000,0, 3,3,0,1,0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,       16'h00B0,1, 3,3,0,1,0));
      tbl.push_back(mk(0,1,0,0,0,0,32'h0,       16'h00B0,1, 3,3,0,1,0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,       16'h00B1,1, 3,3,0,1,0));
      // arm and step together in DONE.
      tbl.push_back(mk(1,1,0,0,0,0,32'h0,       16'hAAAA,1, 3,3,0,0,1));
      tbl.push_back(mk(0,0,1,1,0,0,32'hC0,      16'hFFFF,1, 3,3,0,0,1));
      tbl.push_back(mk(0,0,1,0,0,0,32'hC1,      16'hFFFF,1, 3,3,0,0,1));

      tick(0,0,0,0,0,0,32'h0,1'b1);
      tick(0,0,0,0,0,0,32'h0,1'b1);
      chk("reset_leds", 32'(leds), 32'h5555);

      for (int i = 0; i < tbl.size(); i++) begin
         tick(tbl[i].a, tbl[i].s, tbl[i].v, tbl[i].so, tbl[i].eo, tbl[i].em, tbl[i].d, 1'b0);
         if (tbl[i].ck) chk($sformatf("tbl%0d_leds", i), 32'(leds), 32'(tbl[i].e_leds));
         chk($sformatf("tbl%0d_len", i), 32'(pkt_len), tbl[i].e_len);
         chk($sformatf("tbl%0d_le", i), 32'(last_empty), tbl[i].e_le);
         chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
         chk($sformatf("tbl%0d_serr", i), 32'(sop_err), 32'(tbl[i].e_serr));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      end

      // Reset while capturing abandons the packet.
      tick(0,0,1,0,0,0,32'hC2,1'b1);
      chk("rst_capt_leds", 32'(leds), 32'h5555);
      chk("rst_capt_len", 32'(pkt_len), 32'd0);
      chk("rst_capt_busy", 32'(busy), 32'd0);

      for (int n = 0; n < 4000; n++) begin
         tick(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), $urandom,
              ($urandom_range(0, 499) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pkt_capture_ctrl.md
# pkt_capture_ctrl

Packet capture controller for the DE2 Ethernet test sink. Sequences a single-port word RAM (`ram_v1`) to record exactly one Avalon-ST packet per arm request, from `sop` to `eop`. It then lets the operator step through the captured words on the board LEDs. It replaces free-running, counter-addressed capture with a small state machine, a write pointer, a read pointer and packet-length bookkeeping.

## Interface
- `WIDTH`, 32, Avalon-ST data width in bits (multiple of 8, ≥16).
- `ADDR_WIDTH`, 10, RAM address width; capture depth = 2^ADDR_WIDTH words.
- `EMPTY_WIDTH`, $clog2(WIDTH/8), width of `empty`.

Ports:
- `clk` in 1: single clock; everything is synchronous to its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `arm` in 1: single-cycle pulse (debounced button0) requesting a new capture.
- `step` in 1: single-cycle pulse (debounced button1) advancing the readout pointer.
- `ready` out 1: Avalon-ST ready; constant 1 after reset, so the sink never back-pressures.
- `data` in WIDTH: Avalon-ST data.
- `valid` in 1: Avalon-ST valid.
- `sop` in 1: start of packet.
- `eop` in 1: end of packet.
- `empty` in EMPTY_WIDTH: unused bytes on the `eop` beat.
- `LEDS` out 16: display output.
- `pkt_len` out ADDR_WIDTH+1: number of words captured.
- `last_empty` out EMPTY_WIDTH: `empty` value latched on the `eop` beat.
- `overflow` out 1: capture truncated at RAM full.
- `sop_err` out 1: `sop` arrived mid-packet and capture restarted.
- `busy` out 1: high in ARMED or CAPTURE.

## Operation
- A beat is a cycle with `valid && ready`.
- **IDLE:**
  - Beats are discarded.
  - `arm` → ARMED; clears `wr_ptr`, `overflow` and `sop_err`.
- **ARMED:**
  - Beats without `sop` are discarded.
  - A beat with `sop` is written at address 0 and `wr_ptr` becomes 1.
  - If that beat also has `eop`, go to DONE with `pkt_len`=1. Otherwise go to CAPTURE.
- **CAPTURE:** every beat is written at `wr_ptr`, then `wr_ptr` increments.
  - `eop` beat → DONE; `pkt_len` = `wr_ptr`+1; latch `last_empty`.
  - Beat written at address 2^ADDR_WIDTH−1 without `eop` → DONE; set `overflow`; `pkt_len` = 2^ADDR_WIDTH. Later beats are discarded.
  - Beat with `sop` (and without `eop`): rewrite that beat at address 0, set `wr_ptr`=1, set `sop_err`, stay in CAPTURE.
  - `arm` is ignored.
- **DONE:**
  - `rd_ptr` is cleared on entry.
  - `step` increments `rd_ptr`, wrapping from `pkt_len`−1 to 0.
  - `arm` → ARMED. If `arm` and `step` occur in the same cycle, `arm` wins.
- **RAM addressing:**
  - RAM address = `wr_ptr` in ARMED/CAPTURE, `rd_ptr` otherwise.
  - `wr_en` = beat accepted for writing, combinational.
- **LEDS:**
  - IDLE: 16'h5555.
  - ARMED: 16'hAAAA.
  - CAPTURE: 16'hFFFF.
  - DONE: RAM read data [15:0].
- **Reset:**
  - State → IDLE; all pointers, `pkt_len`, `last_empty`, `overflow` and `sop_err` → 0.
  - `LEDS` → 16'h5555; `busy` → 0; `ready` → 1.
  - RAM contents are not cleared. Reset during CAPTURE abandons the packet.

## Timing
- Write occurs in the same cycle as the accepted beat (address, data and `wr_en` are combinational from the beat).
- State, `pkt_len` and flags update on the edge that ends the `eop` beat. They are visible the next cycle.
- RAM read latency is 1 cycle. DONE is entered at cycle N, so `rd_ptr`=0 at N and `LEDS` show word 0 from N+1.
- `step` at cycle M updates `rd_ptr` at M+1; `LEDS` show the new word at M+2.
- `arm` at cycle K puts the block in ARMED at K+1. A `sop` beat at K+1 or later is captured.
- A `sop` beat during the `arm` cycle itself is discarded.
- No bubbles are required: back-to-back beats are written on consecutive cycles.

## Structure
- Package `pkt_cap_pkg` contains:
  - `cap_state_t` enum (IDLE, ARMED, CAPTURE, DONE).
  - LED pattern constants (`LED_IDLE`, `LED_ARMED`, `LED_CAPT`).
- One sub-module: the existing `ram_v1` (ADDR_WIDTH, DATA_WIDTH=WIDTH), instantiated internally. The controller owns its address, `wr_en` and `data_in`.
- Controller FSM, pointers and LED mux live in `pkt_capture_ctrl`.

## Test plan
- Arm, then send a 4-beat packet 0x11,0x22,0x33,0x44 with `empty`=2 on `eop` → DONE; `pkt_len`=4, `last_empty`=2, `LEDS`=0x0011. Four steps → 0x0022, 0x0033, 0x0044, 0x0011 (wrap).
- Traffic before `arm` and a non-`sop` beat in ARMED → not written; first `sop` beat lands at address 0.
- Single-beat packet (`sop`+`eop` together) → DONE with `pkt_len`=1; `step` keeps `LEDS` at word 0.
- With ADDR_WIDTH=3, send a 12-beat packet → `overflow`=1, `pkt_len`=8, words 0–7 stored, beats 8–11 dropped.
- `sop` at beat 3 of a packet, then 2 more beats with `eop` → `sop_err`=1, `pkt_len`=3, word 0 = restart beat.
- Assert `rst` mid-CAPTURE → next cycle IDLE, `LEDS`=0x5555, `pkt_len`=0, `busy`=0. Simultaneous `arm`+`step` in DONE → ARMED.
